// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout and illegal-opcode trap.
// Optional performance counters (CycleCnt, InstRet) are built when MCU_PERF_COUNTERS_EN is defined.
module multicycle_control_unit #(
  parameter int MEM_WAIT_MAX = 15,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  OpCode,
  input  logic [2:0]  F3,
  input  logic [6:0]  F7,
  input  logic        BrTaken,
  input  logic        MemReady,
  output logic        IMReq,
  output logic        IRWr,
  output logic        PCWr,
  output logic [2:0]  ImmSrc,
  output logic        ALUASrc,
  output logic        ALUBSrc,
  output logic [3:0]  ALUOp,
  output logic        DMRd,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  output logic [1:0]  RUDataWrSrc,
  output logic        RUWr,
  output logic [4:0]  BrOp,
  output logic        Illegal,
  output logic        Timeout,
  output logic [2:0]  State
`ifdef MCU_PERF_COUNTERS_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstRet
`endif
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    K_R, K_I, K_LD, K_ST, K_B, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD
  } kind_e;

  function automatic kind_e classify(input logic [6:0] op);
    kind_e k;
    case (op)
      OP_R:     k = K_R;
      OP_I:     k = K_I;
      OP_LD:    k = K_LD;
      OP_ST:    k = K_ST;
      OP_B:     k = K_B;
      OP_JAL:   k = K_JAL;
      OP_JALR:  k = K_JALR;
      OP_LUI:   k = K_LUI;
      OP_AUIPC: k = K_AUIPC;
      default:  k = K_BAD;
    endcase
    return k;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [6:0]       op_q, op_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7b5_q, f7b5_d;

  kind_e kind_in, kind_q;

  logic       imreq_c, irwr_c, pcwr_c, alua_c, alub_c;
  logic       dmrd_c, dmwr_c, ruwr_c;
  logic [2:0] immsrc_c, dmctrl_c;
  logic [3:0] aluop_c;
  logic [1:0] rusrc_c;
  logic [4:0] brop_c;

  // BrTaken and the remaining F7 bits steer the datapath PC mux / ALU, not the sequencing.
  logic unused_inputs;
  assign unused_inputs = ^{BrTaken, F7[6], F7[4:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    op_d      = op_q;
    f3_d      = f3_q;
    f7b5_d    = f7b5_q;
    imreq_c   = 1'b0;
    irwr_c    = 1'b0;
    pcwr_c    = 1'b0;
    alua_c    = 1'b0;
    alub_c    = 1'b0;
    dmrd_c    = 1'b0;
    dmwr_c    = 1'b0;
    ruwr_c    = 1'b0;
    immsrc_c  = 3'b000;
    dmctrl_c  = 3'b000;
    aluop_c   = 4'b0000;
    rusrc_c   = 2'b00;
    brop_c    = 5'b00000;
    kind_in   = classify(OpCode);
    kind_q    = classify(op_q);

    case (state_q)
      S_FETCH: begin
        imreq_c = 1'b1;
        if (MemReady) begin
          irwr_c  = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        op_d   = OpCode;
        f3_d   = F3;
        f7b5_d = F7[5];
        if (kind_in != K_BAD) begin
          state_d = S_EXEC;
        end else if (ILLEGAL_TRAP) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          pcwr_c  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        case (kind_q)
          K_R: aluop_c = {f7b5_q, f3_q};
          K_I: begin
            alub_c  = 1'b1;
            aluop_c = (f3_q == 3'b101) ? {f7b5_q, f3_q} : {1'b0, f3_q};
          end
          K_LD: begin
            alub_c  = 1'b1;
            state_d = S_MEM;
          end
          K_ST: begin
            alub_c   = 1'b1;
            immsrc_c = 3'b001;
            state_d  = S_MEM;
          end
          K_JALR: begin
            alub_c = 1'b1;
            brop_c = 5'b10000;
          end
          K_B: begin
            alua_c   = 1'b1;
            alub_c   = 1'b1;
            immsrc_c = 3'b101;
            brop_c   = {2'b01, f3_q};
            pcwr_c   = 1'b1;
            state_d  = S_FETCH;
          end
          K_JAL: begin
            alua_c   = 1'b1;
            alub_c   = 1'b1;
            immsrc_c = 3'b010;
            brop_c   = 5'b10000;
          end
          K_AUIPC: begin
            alua_c   = 1'b1;
            alub_c   = 1'b1;
            immsrc_c = 3'b010;
          end
          K_LUI: begin
            alub_c   = 1'b1;
            immsrc_c = 3'b010;
            aluop_c  = 4'b1111;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        dmrd_c   = (kind_q == K_LD);
        dmwr_c   = (kind_q == K_ST);
        dmctrl_c = f3_q;
        if (MemReady) begin
          if (kind_q == K_ST) begin
            pcwr_c  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        ruwr_c  = 1'b1;
        pcwr_c  = 1'b1;
        state_d = S_FETCH;
        if (kind_q == K_LD) begin
          rusrc_c = 2'b01;
        end else if (kind_q == K_JAL || kind_q == K_JALR) begin
          rusrc_c = 2'b10;
          brop_c  = 5'b10000;
        end
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_TRAP;
    endcase

    // The wait budget restarts whenever a new request phase begins.
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    f3_q   <= f3_d;
    f7b5_q <= f7b5_d;
  end

  always_comb begin
    IMReq       = rst_n & imreq_c;
    IRWr        = rst_n & irwr_c;
    PCWr        = rst_n & pcwr_c;
    ImmSrc      = rst_n ? immsrc_c : 3'b000;
    ALUASrc     = rst_n & alua_c;
    ALUBSrc     = rst_n & alub_c;
    ALUOp       = rst_n ? aluop_c : 4'b0000;
    DMRd        = rst_n & dmrd_c;
    DMWr        = rst_n & dmwr_c;
    DMCtrl      = rst_n ? dmctrl_c : 3'b000;
    RUDataWrSrc = rst_n ? rusrc_c : 2'b00;
    RUWr        = rst_n & ruwr_c;
    BrOp        = rst_n ? brop_c : 5'b00000;
    Illegal     = rst_n & illegal_q;
    Timeout     = rst_n & timeout_q;
    State       = rst_n ? state_q : S_FETCH;
  end

`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q + ((state_q != S_TRAP) ? 32'd1 : 32'd0);
    ret_d = ret_q + (pcwr_c ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign CycleCnt = rst_n ? cyc_q : 32'd0;
  assign InstRet  = rst_n ? ret_q : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a per-instruction trace model predicts every cycle's outputs.
module tb_multicycle_control_unit;
  localparam int MAXW     = 15;
  localparam bit ILL_TRAP = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] OpCode = '0;
  logic [2:0] F3 = '0;
  logic [6:0] F7 = '0;
  logic BrTaken = 1'b0;
  logic MemReady = 1'b0;
  logic IMReq, IRWr, PCWr, ALUASrc, ALUBSrc, DMRd, DMWr, RUWr, Illegal, Timeout;
  logic [2:0] ImmSrc, DMCtrl, State;
  logic [3:0] ALUOp;
  logic [1:0] RUDataWrSrc;
  logic [4:0] BrOp;
`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] CycleCnt, InstRet;
`endif

  multicycle_control_unit #(.MEM_WAIT_MAX(MAXW), .ILLEGAL_TRAP(ILL_TRAP)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .F3(F3), .F7(F7), .BrTaken(BrTaken),
    .MemReady(MemReady), .IMReq(IMReq), .IRWr(IRWr), .PCWr(PCWr), .ImmSrc(ImmSrc),
    .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOp(ALUOp), .DMRd(DMRd), .DMWr(DMWr),
    .DMCtrl(DMCtrl), .RUDataWrSrc(RUDataWrSrc), .RUWr(RUWr), .BrOp(BrOp),
    .Illegal(Illegal), .Timeout(Timeout), .State(State)
`ifdef MCU_PERF_COUNTERS_EN
    , .CycleCnt(CycleCnt), .InstRet(InstRet)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imreq, irwr, pcwr;
    logic [2:0] imm;
    logic       asrc, bsrc;
    logic [3:0] aluop;
    logic       dmrd, dmwr;
    logic [2:0] dmctrl;
    logic [1:0] rus;
    logic       ruwr;
    logic [4:0] brop;
    logic       ill, tmo;
    logic [2:0] st;
  } out_t;

  typedef struct {
    bit rst_n; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; bit br; bit mr; out_t exp; string tag;
  } item_t;

  typedef struct { bit rst; out_t exp; string tag; } sb_t;

  typedef enum {C_R, C_I, C_LD, C_ST, C_B, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD} cls_t;

  out_t act;
  assign act = {IMReq, IRWr, PCWr, ImmSrc, ALUASrc, ALUBSrc, ALUOp, DMRd, DMWr, DMCtrl,
                RUDataWrSrc, RUWr, BrOp, Illegal, Timeout, State};

  item_t plan[$];
  sb_t   sb[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";
  logic [6:0] valid_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_B;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_BAD;
    endcase
  endfunction

  // Cycle with junk instruction fields: the unit must only sample them in DECODE.
  task automatic add(input out_t e, input bit mr);
    item_t it;
    it.rst_n = 1'b1; it.op = 7'($urandom); it.f3 = 3'($urandom); it.f7 = 7'($urandom);
    it.br = 1'($urandom); it.mr = mr; it.exp = e; it.tag = cur_tag;
    plan.push_back(it);
  endtask

  task automatic add_dec(input out_t e, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    item_t it;
    it.rst_n = 1'b1; it.op = op; it.f3 = f3; it.f7 = f7;
    it.br = 1'($urandom); it.mr = 1'($urandom); it.exp = e; it.tag = cur_tag;
    plan.push_back(it);
  endtask

  task automatic add_reset();
    item_t it;
    it.rst_n = 1'b0; it.op = 7'($urandom); it.f3 = 3'($urandom); it.f7 = 7'($urandom);
    it.br = 1'($urandom); it.mr = 1'($urandom); it.exp = '0; it.tag = "reset";
    plan.push_back(it);
  endtask

  task automatic trap_tail(input bit ill, input bit tmo);
    out_t e;
    repeat (3) begin
      e = '0; e.st = 3'd7; e.ill = ill; e.tmo = tmo;
      add(e, 1'($urandom));
    end
    add_reset();
  endtask

  // Expected trace of one instruction: wf fetch waits, wm data-memory waits.
  task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int wf, input int wm);
    out_t e;
    cls_t c;
    bit   is_jump;
    c = classify(op);
    is_jump = (c == C_JAL) || (c == C_JALR);
    for (int i = 0; i < wf && i < MAXW; i++) begin
      e = '0; e.imreq = 1'b1; add(e, 1'b0);
    end
    if (wf >= MAXW) begin trap_tail(1'b0, 1'b1); return; end
    e = '0; e.imreq = 1'b1; e.irwr = 1'b1; add(e, 1'b1);
    e = '0; e.st = 3'd1;
    if (c == C_BAD && !ILL_TRAP) e.pcwr = 1'b1;
    add_dec(e, op, f3, f7);
    if (c == C_BAD) begin
      if (ILL_TRAP) trap_tail(1'b1, 1'b0);
      return;
    end
    e = '0; e.st = 3'd2;
    case (c)
      C_R:     e.aluop = {f7[5], f3};
      C_I:     begin e.bsrc = 1'b1; e.aluop = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3}; end
      C_LD:    e.bsrc = 1'b1;
      C_JALR:  e.bsrc = 1'b1;
      C_ST:    begin e.bsrc = 1'b1; e.imm = 3'b001; end
      C_B:     begin e.asrc = 1'b1; e.bsrc = 1'b1; e.imm = 3'b101; e.brop = {2'b01, f3}; e.pcwr = 1'b1; end
      C_JAL:   begin e.asrc = 1'b1; e.bsrc = 1'b1; e.imm = 3'b010; end
      C_AUIPC: begin e.asrc = 1'b1; e.bsrc = 1'b1; e.imm = 3'b010; end
      C_LUI:   begin e.bsrc = 1'b1; e.imm = 3'b010; e.aluop = 4'b1111; end
      default: e.st = 3'd2;
    endcase
    if (is_jump) e.brop = 5'b10000;
    add(e, 1'($urandom));
    if (c == C_B) return;
    if (c == C_LD || c == C_ST) begin
      e = '0; e.st = 3'd3; e.dmrd = (c == C_LD); e.dmwr = (c == C_ST); e.dmctrl = f3;
      for (int i = 0; i < wm && i < MAXW; i++) add(e, 1'b0);
      if (wm >= MAXW) begin trap_tail(1'b0, 1'b1); return; end
      if (c == C_ST) e.pcwr = 1'b1;
      add(e, 1'b1);
      if (c == C_ST) return;
    end
    e = '0; e.st = 3'd4; e.ruwr = 1'b1; e.pcwr = 1'b1;
    e.rus = (c == C_LD) ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
    if (is_jump) e.brop = 5'b10000;
    add(e, 1'($urandom));
  endtask

  // Drive the planned cycles; abort_at >= 0 replaces the rest with a reset cycle.
  task automatic play(input int abort_at);
    item_t it;
    sb_t   s;
    int    n;
    n = 0;
    while (plan.size() > 0) begin
      if (abort_at >= 0 && n == abort_at) begin
        plan.delete();
        add_reset();
        abort_at = -1;
      end
      it = plan.pop_front();
      @(posedge clk);
      #1;
      rst_n = it.rst_n; OpCode = it.op; F3 = it.f3; F7 = it.f7; BrTaken = it.br; MemReady = it.mr;
      s.rst = !it.rst_n; s.exp = it.exp; s.tag = it.tag;
      sb.push_back(s);
      n++;
    end
  endtask

  sb_t cur;
`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;
`endif

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s state=%0d: outputs got %h required %h", cur.tag, cur.exp.st, act, cur.exp);
      end
`ifdef MCU_PERF_COUNTERS_EN
      if (cur.rst) begin
        m_cyc = '0;
        m_ret = '0;
      end else begin
        checks++;
        if (CycleCnt !== m_cyc || InstRet !== m_ret) begin
          errors++;
          $display("FAIL %s perf: got cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                   cur.tag, CycleCnt, InstRet, m_cyc, m_ret);
        end
        m_cyc = m_cyc + ((cur.exp.st != 3'd7) ? 32'd1 : 32'd0);
        m_ret = m_ret + (cur.exp.pcwr ? 32'd1 : 32'd0);
      end
`endif
    end
  end

  initial begin
    int guard;
    logic [6:0] op;
    add_reset(); add_reset(); play(-1);
    cur_tag = "add";     gen_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0); play(-1);
    cur_tag = "srai";    gen_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0); play(-1);
    cur_tag = "slli";    gen_instr(7'b0010011, 3'b001, 7'b0000000, 1, 0); play(-1);
    cur_tag = "lw_w3";   gen_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3); play(-1);
    cur_tag = "beq";     gen_instr(7'b1100011, 3'b000, 7'b0000000, 0, 0); play(-1);
    cur_tag = "sw";      gen_instr(7'b0100011, 3'b010, 7'b0000000, 0, 0); play(-1);
    cur_tag = "sw_lim";  gen_instr(7'b0100011, 3'b000, 7'b0000000, 2, MAXW - 1); play(-1);
    cur_tag = "jal";     gen_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0); play(-1);
    cur_tag = "jalr";    gen_instr(7'b1100111, 3'b000, 7'b0000000, 0, 0); play(-1);
    cur_tag = "lui";     gen_instr(7'b0110111, 3'b011, 7'b1010101, 0, 0); play(-1);
    cur_tag = "auipc";   gen_instr(7'b0010111, 3'b110, 7'b0000000, 0, 0); play(-1);
    cur_tag = "f_lim";   gen_instr(7'b0110011, 3'b111, 7'b0100000, MAXW - 1, 0); play(-1);
    cur_tag = "f_tmo";   gen_instr(7'b0110011, 3'b000, 7'b0000000, MAXW, 0); play(-1);
    cur_tag = "illegal"; gen_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0); play(-1);
    cur_tag = "st_tmo";  gen_instr(7'b0100011, 3'b001, 7'b0000000, 0, MAXW); play(-1);
    cur_tag = "abort";   gen_instr(7'b0000011, 3'b100, 7'b0000000, 0, 2); play(4);
    cur_tag = "add2";    gen_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0); play(-1);
    for (int k = 0; k < 200; k++) begin
      int wf, wm;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : valid_ops[$urandom_range(0, 8)];
      wf = ($urandom_range(0, 11) == 0) ? $urandom_range(0, MAXW + 1) : $urandom_range(0, 2);
      wm = ($urandom_range(0, 11) == 0) ? $urandom_range(0, MAXW + 1) : $urandom_range(0, 3);
      cur_tag = "rand";
      gen_instr(op, 3'($urandom), 7'($urandom), wf, wm);
      if ($urandom_range(0, 19) == 0) play($urandom_range(0, plan.size() - 1));
      else play(-1);
    end
    @(negedge clk);
    #1;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
